// File: rtl/tone_io_b3.sv
// ---------------------------------------------------------------------------
// tone_io_b3
//
// Multi-channel square-wave tone generator on the AVR 8-bit I/O port bus.
// Each channel has a 16-bit half-period (in tone ticks), a 4-bit volume and a
// one-shot duration timer (in duration ticks). The audible channels are summed
// and fed to a first-order sigma-delta modulator that drives a 1-bit pin.
//
// Register map (channel c at 4c+0..4c+3, globals at G = 4*N_CHAN):
//   4c+0  period lo   write: shadow only, read: committed period[7:0]
//   4c+1  period hi   write: commit {data_in, shadow}, restart phase
//   4c+2  volume      low nibble only
//   4c+3  duration    write: load timer and start channel (0 = endless)
//   G+0   enable mask
//   G+1   status      read: active bits, write: 1-to-stop
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   addr       port address
//   data_out   combinational read data (0 when re=0 or unmapped)
//   data_in    write data
//   re         read enable
//   we         write enable
//   signal_out sigma-delta audio bit (registered)
// ---------------------------------------------------------------------------
module tone_io_b3 #(
    parameter int N_CHAN   = 4,
    parameter int ADDR_W   = 5,
    parameter int TONE_DIV = 100,
    parameter int DUR_DIV  = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_out,
    input  logic [7:0]        data_in,
    input  logic              re,
    input  logic              we,
    output logic              signal_out
);

    // Mixer width: enough headroom for N_CHAN channels at full volume.
    localparam int MW = 4 + $clog2(N_CHAN + 1);
    localparam int G  = 4 * N_CHAN;

    logic [7:0]        shadow_lo [N_CHAN];
    logic [15:0]       period    [N_CHAN];
    logic [3:0]        volume    [N_CHAN];
    logic [7:0]        dur_cnt   [N_CHAN];
    logic [15:0]       tone_cnt  [N_CHAN];
    logic [N_CHAN-1:0] active;
    logic [N_CHAN-1:0] timed;
    logic [N_CHAN-1:0] sq;
    logic [N_CHAN-1:0] enable;

    logic [31:0]       tone_pre;
    logic [31:0]       dur_pre;
    logic              tone_tick;
    logic              dur_tick;
    logic              wr_enable;
    logic              wr_status;

    logic [MW-1:0]     mix;
    logic [MW:0]       acc;

    assign tone_tick = (tone_pre == 32'(TONE_DIV - 1));
    assign dur_tick  = (dur_pre  == 32'(DUR_DIV - 1));
    assign wr_enable = we && (addr == ADDR_W'(G));
    assign wr_status = we && (addr == ADDR_W'(G + 1));

    // Shared prescalers; each tick is a single-cycle strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            tone_pre <= '0;
            dur_pre  <= '0;
        end else begin
            tone_pre <= tone_tick ? '0 : tone_pre + 32'd1;
            dur_pre  <= dur_tick  ? '0 : dur_pre  + 32'd1;
        end
    end

    // Per-channel registers, tone phase and duration timer.
    // A period commit restarts the phase so the new pitch starts cleanly at
    // sq=0; CPU duration/stop writes take priority over a coincident dur_tick.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CHAN; c++) begin
            if (reset) begin
                shadow_lo[c] <= '0;
                period[c]    <= '0;
                volume[c]    <= '0;
                dur_cnt[c]   <= '0;
                tone_cnt[c]  <= '0;
                active[c]    <= 1'b0;
                timed[c]     <= 1'b0;
                sq[c]        <= 1'b0;
            end else begin
                if (we && addr == ADDR_W'(4 * c))
                    shadow_lo[c] <= data_in;
                if (we && addr == ADDR_W'(4 * c + 2))
                    volume[c] <= data_in[3:0];

                if (we && addr == ADDR_W'(4 * c + 1)) begin
                    period[c]   <= {data_in, shadow_lo[c]};
                    tone_cnt[c] <= '0;
                    sq[c]       <= 1'b0;
                end else if (period[c] == 16'd0) begin
                    tone_cnt[c] <= '0;
                    sq[c]       <= 1'b0;
                end else if (tone_tick) begin
                    if (tone_cnt[c] == period[c] - 16'd1) begin
                        tone_cnt[c] <= '0;
                        sq[c]       <= ~sq[c];
                    end else begin
                        tone_cnt[c] <= tone_cnt[c] + 16'd1;
                    end
                end

                if (we && addr == ADDR_W'(4 * c + 3)) begin
                    dur_cnt[c] <= data_in;
                    active[c]  <= 1'b1;
                    timed[c]   <= (data_in != 8'd0);
                end else if (wr_status && data_in[c]) begin
                    dur_cnt[c] <= '0;
                    active[c]  <= 1'b0;
                    timed[c]   <= 1'b0;
                end else if (dur_tick && timed[c]) begin
                    if (dur_cnt[c] > 8'd1) begin
                        dur_cnt[c] <= dur_cnt[c] - 8'd1;
                    end else if (dur_cnt[c] == 8'd1) begin
                        dur_cnt[c] <= '0;
                        active[c]  <= 1'b0;
                        timed[c]   <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            enable <= '0;
        else if (wr_enable)
            enable <= data_in[N_CHAN-1:0];
    end

    // Digital mixer: sum of the volumes of every audible channel.
    always_comb begin
        mix = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (enable[c] && active[c] && (period[c] != 16'd0) && sq[c])
                mix = mix + MW'(volume[c]);
        end
    end

    // First-order sigma-delta: the carry out of the MW-bit accumulator is the
    // output bit. acc is a register, so signal_out is registered as well and
    // drops to 0 one cycle after mix goes to 0.
    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else
            acc <= {1'b0, acc[MW-1:0]} + (MW+1)'(mix);
    end

    assign signal_out = acc[MW];

    // Combinational read mux.
    always_comb begin
        data_out = '0;
        if (re) begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (addr == ADDR_W'(4 * c))
                    data_out = period[c][7:0];
                if (addr == ADDR_W'(4 * c + 1))
                    data_out = period[c][15:8];
                if (addr == ADDR_W'(4 * c + 2))
                    data_out = {4'd0, volume[c]};
                if (addr == ADDR_W'(4 * c + 3))
                    data_out = dur_cnt[c];
            end
            if (addr == ADDR_W'(G))
                data_out = 8'(enable);
            if (addr == ADDR_W'(G + 1))
                data_out = 8'(active);
        end
    end

endmodule

// File: tb/tb_tone_io_b3.sv
// ---------------------------------------------------------------------------
// tb_tone_io_b3
//
// Self-checking bench for tone_io_b3 with fast prescalers (TONE_DIV=4,
// DUR_DIV=16). A behavioural model tracks each channel as "tone ticks since
// the last period commit" and derives the square wave as
// (ticks / period) mod 2; durations, register readback and the sigma-delta
// carry stream are computed from the same channel-level view. data_out and
// signal_out are compared against the model every cycle, with directed
// sections for commit, expiry, stop collisions, density and gating.
// ---------------------------------------------------------------------------
module tb_tone_io_b3;

    localparam int N_CHAN   = 4;
    localparam int ADDR_W   = 5;
    localparam int TONE_DIV = 4;
    localparam int DUR_DIV  = 16;
    localparam int G        = 4 * N_CHAN;
    localparam int MW       = 4 + $clog2(N_CHAN + 1);
    localparam int ACC_MOD  = 1 << MW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic [7:0]        data_out;
    logic [7:0]        data_in = '0;
    logic              re = 1'b0;
    logic              we = 1'b0;
    logic              signal_out;

    int tests = 0;
    int failures = 0;

    // Reference model state.
    bit model_valid = 0;
    int m_cycle;
    int m_shadow [N_CHAN];
    int m_period [N_CHAN];
    int m_vol    [N_CHAN];
    int m_dur    [N_CHAN];
    int m_active [N_CHAN];
    int m_timed  [N_CHAN];
    int m_ticks  [N_CHAN];
    int m_enable;
    int m_acc;
    int m_sig;

    logic [31:0] last_rd;
    logic [31:0] last_sig;

    tone_io_b3 #(
        .N_CHAN  (N_CHAN),
        .ADDR_W  (ADDR_W),
        .TONE_DIV(TONE_DIV),
        .DUR_DIV (DUR_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .data_out  (data_out),
        .data_in   (data_in),
        .re        (re),
        .we        (we),
        .signal_out(signal_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input int exp);
        tests++;
        if (got !== 32'(exp)) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_sq(input int c);
        if (m_period[c] == 0)
            return 0;
        return (m_ticks[c] / m_period[c]) % 2;
    endfunction

    function automatic int model_mix();
        int s = 0;
        for (int c = 0; c < N_CHAN; c++)
            if (((m_enable >> c) & 1) == 1 && m_active[c] == 1 &&
                m_period[c] != 0 && model_sq(c) == 1)
                s += m_vol[c];
        return s;
    endfunction

    function automatic int model_read();
        int a = int'(addr);
        int mask = 0;
        if (!re)
            return 0;
        if (a < G) begin
            case (a % 4)
                0: return m_period[a/4] & 255;
                1: return m_period[a/4] >> 8;
                2: return m_vol[a/4];
                default: return m_dur[a/4];
            endcase
        end
        if (a == G)
            return m_enable;
        if (a == G + 1) begin
            for (int c = 0; c < N_CHAN; c++)
                mask |= m_active[c] << c;
            return mask;
        end
        return 0;
    endfunction

    // Advance the model across one rising edge using the current bus inputs.
    task automatic model_update();
        int a = int'(addr);
        int d = int'(data_in);
        int total;
        bit tt;
        bit dt;
        if (reset) begin
            for (int c = 0; c < N_CHAN; c++) begin
                m_shadow[c] = 0; m_period[c] = 0; m_vol[c] = 0; m_dur[c] = 0;
                m_active[c] = 0; m_timed[c] = 0; m_ticks[c] = 0;
            end
            m_enable = 0; m_acc = 0; m_sig = 0; m_cycle = 0;
            model_valid = 1;
            return;
        end
        if (!model_valid)
            return;
        m_cycle++;
        tt = (m_cycle % TONE_DIV) == 0;
        dt = (m_cycle % DUR_DIV) == 0;
        total = m_acc + model_mix();
        m_sig = (total >= ACC_MOD) ? 1 : 0;
        m_acc = total % ACC_MOD;
        for (int c = 0; c < N_CHAN; c++) begin
            if (we && a == 4*c)
                m_shadow[c] = d;
            if (we && a == 4*c + 2)
                m_vol[c] = d & 15;
            if (we && a == 4*c + 1) begin
                m_period[c] = d * 256 + m_shadow[c];
                m_ticks[c] = 0;
            end else if (tt && m_period[c] != 0) begin
                m_ticks[c]++;
            end
            if (we && a == 4*c + 3) begin
                m_dur[c] = d; m_active[c] = 1; m_timed[c] = (d != 0) ? 1 : 0;
            end else if (we && a == G + 1 && ((d >> c) & 1) == 1) begin
                m_dur[c] = 0; m_active[c] = 0; m_timed[c] = 0;
            end else if (dt && m_timed[c] == 1) begin
                if (m_dur[c] > 1) begin
                    m_dur[c]--;
                end else if (m_dur[c] == 1) begin
                    m_dur[c] = 0; m_active[c] = 0; m_timed[c] = 0;
                end
            end
        end
        if (we && a == G)
            m_enable = d & ((1 << N_CHAN) - 1);
    endtask

    // One bus cycle: drive inputs after the falling edge, check outputs
    // against the model, then advance both DUT and model by one clock.
    task automatic applyStimulus(input bit w, input bit r, input int a, input int d, input bit rst);
        reset = rst;
        we = w;
        re = r;
        addr = ADDR_W'(a);
        data_in = 8'(d);
        #1;
        last_rd = 32'(data_out);
        last_sig = 32'(signal_out);
        if (model_valid) begin
            checkOutput("data_out", last_rd, model_read());
            checkOutput("signal_out", last_sig, m_sig);
        end
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic writeReg(input int a, input int d);
        applyStimulus(1, 0, a, d, 0);
    endtask

    task automatic readReg(input int a);
        applyStimulus(0, 1, a, 0, 0);
    endtask

    // Idle until the next rising edge carries a duration tick.
    task automatic alignToDurTick();
        for (int i = 0; i < DUR_DIV; i++) begin
            if (((m_cycle + 1) % DUR_DIV) == 0)
                break;
            idle(1);
        end
    endtask

    task automatic countOnes(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            idle(1);
            ones += int'(last_sig);
        end
    endtask

    initial begin
        int ones;
        int busy;
        int a;
        int d;

        // Reset and readback
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i <= G + 1; i++) begin
            readReg(i);
            checkOutput("reset_read", last_rd, 0);
        end
        countOnes(100, ones);
        checkOutput("reset_silence", 32'(ones), 0);

        // Atomic period commit
        writeReg(0, 8'h05);
        readReg(0);
        checkOutput("lo_before_commit", last_rd, 0);
        writeReg(1, 8'h00);
        writeReg(2, 8'hFF);
        writeReg(3, 0);
        writeReg(G, 1);
        readReg(0);
        checkOutput("lo_after_commit", last_rd, 5);
        readReg(2);
        checkOutput("volume_upper_bits", last_rd, 15);
        idle(120);

        // Duration expiry
        writeReg(3, 3);
        busy = 0;
        for (int i = 0; i < 60; i++) begin
            readReg(G + 1);
            busy += int'(last_rd[0]);
        end
        checkOutput("dur_window", 32'((busy >= 2*DUR_DIV + 1) && (busy <= 3*DUR_DIV)), 1);
        readReg(G + 1);
        checkOutput("expired_status", last_rd & 32'h1, 0);
        readReg(3);
        checkOutput("expired_dur", last_rd, 0);

        // Write-1-to-stop colliding with a duration tick
        writeReg(3, 5);
        readReg(G + 1);
        checkOutput("active_before_stop", last_rd & 32'h1, 1);
        alignToDurTick();
        writeReg(G + 1, 1);
        readReg(G + 1);
        checkOutput("stop_on_tick", last_rd & 32'h1, 0);
        alignToDurTick();
        writeReg(3, 7);
        readReg(3);
        checkOutput("dur_load_on_tick", last_rd, 7);

        // Mixing density: two channels at volume 8, both high
        writeReg(0, 200);
        writeReg(4, 200);
        writeReg(2, 8);
        writeReg(6, 8);
        writeReg(3, 0);
        writeReg(7, 0);
        writeReg(1, 0);
        writeReg(5, 0);
        writeReg(G, 3);
        idle(830);
        countOnes(128, ones);
        checkOutput("density_16_of_128", 32'(ones), 16);

        // Gating by enable, then resume without phase reset
        writeReg(G, 0);
        idle(2);
        countOnes(30, ones);
        checkOutput("disabled_silence", 32'(ones), 0);
        writeReg(G, 3);
        idle(64);

        // Gating by period = 0 while active
        writeReg(0, 0);
        writeReg(1, 0);
        writeReg(G, 1);
        idle(2);
        countOnes(30, ones);
        checkOutput("period0_silence", 32'(ones), 0);
        readReg(G + 1);
        checkOutput("period0_still_active", last_rd & 32'h1, 1);

        // Reset mid-tone
        writeReg(0, 5);
        writeReg(1, 0);
        idle(30);
        applyStimulus(0, 0, 0, 0, 1);
        idle(1);
        checkOutput("reset_mid_tone", last_sig, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                applyStimulus(0, 0, 0, 0, 1);
            end else begin
                a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(G + 2, 31))
                                                : int'($urandom_range(0, G + 1));
                d = int'($urandom_range(0, 255));
                if (a < G && (a % 4) == 0)
                    d = int'($urandom_range(0, 15));
                if (a < G && (a % 4) == 1)
                    d = int'($urandom_range(0, 1));
                if (a < G && (a % 4) == 3)
                    d = int'($urandom_range(0, 10));
                if (a == G + 1 && $urandom_range(0, 3) != 0)
                    d = 0;
                applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, a, d, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
